alex_spi_tx: RTL
================

// Module: alex_spi_tx
// PURPOSE
//  Serialises the Alex filter/relay control words (the TX word carrying the 7-bit LPF select
//  in bits [6:0], and the RX word) onto the 3-wire Alex SPI bus with separate TX/RX load strobes.
//  Sits between the band decoders and the FPGA pins. A frame is sent only when a word changes,
//  and one frame is forced after reset so the relays always match the registers.
// PARAMETERS
//  CLK_DIV   8   system clocks per SPI half-period (>=2); sck = clock/(2*CLK_DIV)
//  WORD_W    16  bits per frame (tx_word/rx_word width)
// PORTS
//  clock           in   1       system clock; all logic on posedge
//  reset_n         in   1       asynchronous, active-low reset
//  tx_word         in   WORD_W  Alex TX control word (LPF in [6:0]); may change any cycle
//  rx_word         in   WORD_W  Alex RX control word (HPF/attenuator/antenna)
//  spi_sdo         out  1       serial data, MSB first
//  spi_sck         out  1       serial clock, idles low
//  tx_load_strobe  out  1       latches the shifted word into the Alex TX register
//  rx_load_strobe  out  1       latches the shifted word into the Alex RX register
//  busy            out  1       high from frame start to end of gap
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; sent_tx/sent_rx shadows cleared; pend_tx=pend_rx=1 (forced frames).
//  Change detect (every cycle): tx_word!=sent_tx sets pend_tx; rx_word!=sent_rx sets pend_rx.
//  IDLE: if pend_tx select TX, else if pend_rx select RX; selected word copied to shift_reg and
//   to its sent_* shadow, its pend cleared, busy=1 next cycle. TX has priority when both pend.
//  Word is captured at frame start; input changes during a frame set pend again and cause a
//   further frame after the current one (no frame aborted, none lost; last value wins).
//  SHIFT: for bit i = WORD_W-1 downto 0: sdo=shift_reg[i], sck=0 for CLK_DIV clocks, then sck=1
//   for CLK_DIV clocks (slave samples on rising sck; sdo changes only while sck low).
//  STROBE: sck=0, sdo=0, selected strobe=1 for CLK_DIV clocks; the other strobe stays 0.
//  GAP: all outputs 0 except busy=1, for CLK_DIV clocks; then IDLE (busy=0).
//  Frame length: 1 + (2*WORD_W+2)*CLK_DIV clocks from IDLE decision to IDLE re-entry
//   (CLK_DIV=8, WORD_W=16: 273 clocks). Back-to-back frames: next selection on IDLE re-entry.
//  Half-period counter: $clog2(CLK_DIV) bits, reloads at CLK_DIV-1, counts down; bit counter
//   $clog2(WORD_W) bits; no free-running wrap outside SHIFT/STROBE/GAP.
//  Reset asserted mid-frame: outputs go 0 immediately (async), both pend set, frames restart.
//  Outputs registered; no glitches on sck/sdo/strobes.
// STRUCTURE
//  alex_pkg: state enum {IDLE,SHIFT_LO,SHIFT_HI,STROBE,GAP}; LPF code constants
//   LPF_160M=7'b0001000, LPF_80M=7'b0000100, LPF_40M=7'b0000010, LPF_20M=7'b0000001,
//   LPF_15M=7'b1000000, LPF_10M=7'b0100000, LPF_6M=7'b0010000; Alex word field offsets.
//  Sub-module alex_spi_tick: CLK_DIV down-counter, 'tick' on terminal count, cleared by 'start'.
//  Top: change detect, arbiter, FSM, shift register, bit counter.
// TESTING (CLK_DIV=4, WORD_W=16; bench model samples sdo on sck rise, latches on strobe)
//  Reset release, tx=16'h0008, rx=16'h1234 -> TX frame 16'h0008 then RX frame 16'h1234, each
//   137 clocks, tx strobe only on first, rx strobe only on second.
//  Idle, words stable 1000 clocks -> sck/sdo/strobes/busy remain 0.
//  tx_word 16'h0008 -> 16'h0040 -> one TX frame, 16 rising sck edges, model latches 16'h0040.
//  tx and rx change same cycle -> TX frame first, RX frame starts on IDLE re-entry.
//  tx_word changes to 16'h0010 at bit 5 of a frame sending 16'h0001 -> current frame completes
//   with 16'h0001, second frame sends 16'h0010; final latched value 16'h0010.
//  reset_n low at bit 8 of a frame -> all outputs 0 same cycle; after release both frames resent.

Source files
------------

// File: rtl/alex_pkg.sv
// Shared FSM state type and Alex control-word constants for the Alex SPI serialiser.
package alex_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    STROBE,
    GAP
  } state_t;

  // One-hot low-pass filter select codes carried in the TX word
  localparam logic [6:0] LPF_160M = 7'b0001000;
  localparam logic [6:0] LPF_80M  = 7'b0000100;
  localparam logic [6:0] LPF_40M  = 7'b0000010;
  localparam logic [6:0] LPF_20M  = 7'b0000001;
  localparam logic [6:0] LPF_15M  = 7'b1000000;
  localparam logic [6:0] LPF_10M  = 7'b0100000;
  localparam logic [6:0] LPF_6M   = 7'b0010000;

  localparam int LPF_LSB = 0;
  localparam int LPF_W   = 7;

endpackage

// File: rtl/alex_spi_tick.sv
// Half-period timer: down-counter reloaded by start, pulses tick on terminal count while enabled.
// Holds its value when disabled so it never free-runs between frames.
module alex_spi_tick #(
  parameter int CLK_DIV = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(CLK_DIV - 1);
    end else if (en) begin
      cnt <= (cnt == '0) ? CW'(CLK_DIV - 1) : cnt - CW'(1);
    end
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/alex_spi_tx.sv
// Alex relay SPI serialiser: sends TX/RX control words MSB first when they change, then strobes.
// Frame = 1 + (2*WORD_W+2)*CLK_DIV clocks; changes during a frame queue one more frame (last value wins).
module alex_spi_tx
  import alex_pkg::*;
#(
  parameter int CLK_DIV = 8,
  parameter int WORD_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] tx_word,
  input  logic [WORD_W-1:0] rx_word,
  output logic              spi_sdo,
  output logic              spi_sck,
  output logic              tx_load_strobe,
  output logic              rx_load_strobe,
  output logic              busy
);

  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_t            state, next_state;
  logic [WORD_W-1:0] shift_reg, shift_next;
  logic [WORD_W-1:0] sent_tx, sent_rx;
  logic [BW-1:0]     bit_cnt;
  logic              pend_tx, pend_rx;
  logic              sel_rx;
  logic              load, shift_en, tick;

  alex_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (load),
    .en      (state != IDLE),
    .tick    (tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (pend_tx || pend_rx) begin
          next_state = SHIFT_LO;
          load       = 1'b1;
        end
      end
      SHIFT_LO: if (tick) next_state = SHIFT_HI;
      SHIFT_HI: begin
        if (tick) begin
          if (bit_cnt == '0) begin
            next_state = STROBE;
          end else begin
            next_state = SHIFT_LO;
            shift_en   = 1'b1;
          end
        end
      end
      STROBE:  if (tick) next_state = GAP;
      GAP:     if (tick) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // TX wins arbitration whenever both words are pending
  always_comb begin
    shift_next = shift_reg;
    if (load)          shift_next = pend_tx ? tx_word : rx_word;
    else if (shift_en) shift_next = {shift_reg[WORD_W-2:0], 1'b0};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      sel_rx    <= 1'b0;
      sent_tx   <= '0;
      sent_rx   <= '0;
      pend_tx   <= 1'b1;
      pend_rx   <= 1'b1;
    end else begin
      shift_reg <= shift_next;
      if (load)          bit_cnt <= BW'(WORD_W - 1);
      else if (shift_en) bit_cnt <= bit_cnt - BW'(1);
      if (load) sel_rx <= !pend_tx;

      if (load && pend_tx) begin
        sent_tx <= tx_word;
        pend_tx <= 1'b0;
      end else if (tx_word != sent_tx) begin
        pend_tx <= 1'b1;
      end

      if (load && !pend_tx) begin
        sent_rx <= rx_word;
        pend_rx <= 1'b0;
      end else if (rx_word != sent_rx) begin
        pend_rx <= 1'b1;
      end
    end
  end

  // Pins driven from flops fed by next-state decode, so they never glitch
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      spi_sdo        <= 1'b0;
      spi_sck        <= 1'b0;
      tx_load_strobe <= 1'b0;
      rx_load_strobe <= 1'b0;
      busy           <= 1'b0;
    end else begin
      spi_sdo        <= ((next_state == SHIFT_LO) || (next_state == SHIFT_HI)) && shift_next[WORD_W-1];
      spi_sck        <= (next_state == SHIFT_HI);
      tx_load_strobe <= (next_state == STROBE) && !sel_rx;
      rx_load_strobe <= (next_state == STROBE) && sel_rx;
      busy           <= (next_state != IDLE);
    end
  end

endmodule
